// File: rtl/mcpu5_progmem_loader.sv
// Writable program memory for the MCPU5plus core with a bit-serial load port.
// Loads words sequentially from address 0 and holds the CPU in reset while loading.
module mcpu5_progmem_loader #(
    parameter int ADDR_W      = 8,
    parameter int WORD_W      = 6,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] instr,
    input  logic              ld_start,
    input  logic              ld_strobe,
    input  logic              ld_bit,
    input  logic              ld_end,
    output logic              ld_busy,
    output logic [ADDR_W-1:0] ld_addr,
    output logic              ld_wrap,
    output logic              ld_err,
    output logic              cpu_reset
);

    localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(WORD_W - 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
    logic [WORD_W-2:0] sreg_q, sreg_d;
    logic [HC_W-1:0]   holdcnt_q, holdcnt_d;
    logic              ld_wrap_q, ld_wrap_d;
    logic              ld_err_q, ld_err_d;

    logic              mem_we;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem [2**ADDR_W];

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        state_d   = state_q;
        ld_addr_d = ld_addr_q;
        bitcnt_d  = bitcnt_q;
        sreg_d    = sreg_q;
        holdcnt_d = holdcnt_q;
        ld_wrap_d = ld_wrap_q;
        ld_err_d  = ld_err_q;
        mem_we    = 1'b0;
        mem_wdata = {sreg_q, ld_bit};

        // A start request restarts the session from any state and drops any strobe with it.
        if (ld_start) begin
            state_d   = S_SHIFT;
            ld_addr_d = '0;
            bitcnt_d  = '0;
            ld_wrap_d = 1'b0;
            ld_err_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_SHIFT: begin
                    if (ld_strobe) begin
                        if (bitcnt_q == BIT_LAST) begin
                            mem_we    = 1'b1;
                            ld_addr_d = ld_addr_q + ADDR_W'(1);
                            bitcnt_d  = '0;
                            if (&ld_addr_q) ld_wrap_d = 1'b1;
                        end else begin
                            sreg_d   = {sreg_q[WORD_W-3:0], ld_bit};
                            bitcnt_d = bitcnt_q + BC_W'(1);
                        end
                    end
                    if (ld_end) begin
                        state_d   = S_HOLD;
                        holdcnt_d = '0;
                        if (bitcnt_d != '0) ld_err_d = 1'b1;
                        bitcnt_d  = '0;
                    end
                end
                S_HOLD: begin
                    holdcnt_d = holdcnt_q + HC_W'(1);
                    if (holdcnt_q == HOLD_LAST) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ld_addr_q <= '0;
            bitcnt_q  <= '0;
            sreg_q    <= '0;
            holdcnt_q <= '0;
            ld_wrap_q <= 1'b0;
            ld_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_addr_q <= ld_addr_d;
            bitcnt_q  <= bitcnt_d;
            sreg_q    <= sreg_d;
            holdcnt_q <= holdcnt_d;
            ld_wrap_q <= ld_wrap_d;
            ld_err_q  <= ld_err_d;
        end
    end

    // NOTE: the array has no reset so a loaded program survives a system reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[ld_addr_q] <= mem_wdata;
    end

    assign instr     = mem[addr];
    assign ld_busy   = (state_q != S_IDLE);
    assign ld_addr   = ld_addr_q;
    assign ld_wrap   = ld_wrap_q;
    assign ld_err    = ld_err_q;
    assign cpu_reset = reset | ld_busy;

endmodule

// File: tb/tb_mcpu5_progmem_loader.sv
// Directed self-checking bench for mcpu5_progmem_loader.
module tb_mcpu5_progmem_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] addr;
    logic [5:0] instr;
    logic       ld_start, ld_strobe, ld_bit, ld_end;
    logic       ld_busy, ld_wrap, ld_err, cpu_reset;
    logic [7:0] ld_addr;

    int n_checks = 0;
    int n_fail   = 0;

    mcpu5_progmem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .instr     (instr),
        .ld_start  (ld_start),
        .ld_strobe (ld_strobe),
        .ld_bit    (ld_bit),
        .ld_end    (ld_end),
        .ld_busy   (ld_busy),
        .ld_addr   (ld_addr),
        .ld_wrap   (ld_wrap),
        .ld_err    (ld_err),
        .cpu_reset (cpu_reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session();
        ld_start = 1'b1;
        cycle();
        ld_start = 1'b0;
    endtask

    task automatic send_bits(input logic [5:0] w, input int nbits, input int gap);
        for (int i = 5; i > 5 - nbits; i--) begin
            ld_strobe = 1'b1;
            ld_bit    = w[i];
            cycle();
            ld_strobe = 1'b0;
            repeat (gap) cycle();
        end
    endtask

    task automatic end_session();
        ld_end = 1'b1;
        cycle();
        ld_end = 1'b0;
        repeat (2) cycle();
    endtask

    task automatic read_chk(input string tag, input logic [7:0] a, input logic [5:0] exp);
        addr = a;
        #1;
        check(tag, instr, exp);
    endtask

    initial begin
        reset = 1'b1; addr = '0;
        ld_start = 0; ld_strobe = 0; ld_bit = 0; ld_end = 0;
        #2;
        // Reset state
        check("rst_busy", ld_busy, 0);
        check("rst_addr", ld_addr, 0);
        check("rst_wrap", ld_wrap, 0);
        check("rst_err", ld_err, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        cycle();
        reset = 1'b0;
        #1;
        check("rst_release_cpu_reset", cpu_reset, 0);
        cycle();

        // Basic back-to-back load
        start_session();
        check("basic_busy", ld_busy, 1);
        check("basic_cpu_reset", cpu_reset, 1);
        send_bits(6'b111011, 6, 0);
        send_bits(6'b000001, 6, 0);
        send_bits(6'b101010, 6, 0);
        check("basic_addr_pre_end", ld_addr, 3);
        ld_end = 1'b1;
        cycle();
        ld_end = 1'b0;
        check("basic_hold0_cpu_reset", cpu_reset, 1);
        cycle();
        check("basic_hold1_cpu_reset", cpu_reset, 1);
        cycle();
        check("basic_done_cpu_reset", cpu_reset, 0);
        check("basic_done_busy", ld_busy, 0);
        check("basic_addr", ld_addr, 3);
        check("basic_err", ld_err, 0);
        check("basic_wrap", ld_wrap, 0);
        read_chk("basic_mem0", 0, 6'b111011);
        read_chk("basic_mem1", 1, 6'b000001);
        read_chk("basic_mem2", 2, 6'b101010);

        // Reset retains memory
        #2 reset = 1'b1;
        #1;
        check("rst2_cpu_reset", cpu_reset, 1);
        check("rst2_addr", ld_addr, 0);
        read_chk("rst2_mem0", 0, 6'b111011);
        read_chk("rst2_mem2", 2, 6'b101010);
        reset = 1'b0;
        cycle();

        // Overwrite with a known fill, then reload the image with gapped strobes
        start_session();
        for (int w = 0; w < 4; w++) send_bits(6'b010101, 6, 0);
        end_session();
        read_chk("fill_mem0", 0, 6'b010101);
        start_session();
        send_bits(6'b111011, 6, 1);
        send_bits(6'b000001, 6, 2);
        send_bits(6'b101010, 6, 3);
        end_session();
        check("gap_addr", ld_addr, 3);
        read_chk("gap_mem0", 0, 6'b111011);
        read_chk("gap_mem1", 1, 6'b000001);
        read_chk("gap_mem2", 2, 6'b101010);
        read_chk("gap_mem3_unchanged", 3, 6'b010101);

        // Partial word at end of session
        start_session();
        send_bits(6'b110011, 6, 0);
        send_bits(6'b101000, 4, 0);
        end_session();
        check("part_err", ld_err, 1);
        check("part_addr", ld_addr, 1);
        read_chk("part_mem0", 0, 6'b110011);
        read_chk("part_mem1_unchanged", 1, 6'b000001);
        cycle();
        check("part_err_sticky", ld_err, 1);

        // Wrap over 257 words
        start_session();
        check("wrap_start_err_clr", ld_err, 0);
        for (int n = 0; n < 255; n++) send_bits(6'(n), 6, 0);
        check("wrap_addr_255", ld_addr, 255);
        check("wrap_not_yet", ld_wrap, 0);
        send_bits(6'b111111, 6, 0);
        check("wrap_addr_0", ld_addr, 0);
        check("wrap_set", ld_wrap, 1);
        send_bits(6'b000000, 6, 0);
        end_session();
        check("wrap_sticky", ld_wrap, 1);
        check("wrap_addr", ld_addr, 1);
        read_chk("wrap_mem0", 0, 6'b000000);
        read_chk("wrap_mem1", 1, 6'b000001);
        read_chk("wrap_mem200", 200, 6'b001000);
        read_chk("wrap_mem255", 255, 6'b111111);

        // Restart mid-session; the strobe in the restart cycle is dropped
        start_session();
        send_bits(6'b001100, 6, 0);
        send_bits(6'b110000, 6, 0);
        send_bits(6'b101000, 3, 0);
        check("rs_addr_pre", ld_addr, 2);
        ld_start = 1'b1; ld_strobe = 1'b1; ld_bit = 1'b1;
        cycle();
        ld_start = 1'b0; ld_strobe = 1'b0;
        check("rs_addr", ld_addr, 0);
        check("rs_wrap_clr", ld_wrap, 0);
        check("rs_busy", ld_busy, 1);
        send_bits(6'b000111, 6, 0);
        send_bits(6'b111000, 6, 0);
        end_session();
        check("rs_err", ld_err, 0);
        read_chk("rs_mem0", 0, 6'b000111);
        read_chk("rs_mem1", 1, 6'b111000);
        read_chk("rs_mem2_kept", 2, 6'b000010);

        // Asynchronous reset mid-word
        start_session();
        send_bits(6'b101101, 6, 0);
        send_bits(6'b010000, 3, 0);
        #2 reset = 1'b1;
        #1;
        check("mr_busy", ld_busy, 0);
        check("mr_addr", ld_addr, 0);
        check("mr_cpu_reset", cpu_reset, 1);
        reset = 1'b0;
        cycle();
        send_bits(6'b111111, 6, 0);
        check("mr_idle_ignores_strobe", ld_addr, 0);
        read_chk("mr_mem0", 0, 6'b101101);
        read_chk("mr_mem1_kept", 1, 6'b111000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
